// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam int unsigned QUEUE_DEPTH = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {instruction, pc} pairs between instruction memory and decode.
// Flush empties the queue and takes priority over push and pop.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t entries_q [QUEUE_DEPTH];
  fetch_entry_t entries_d [QUEUE_DEPTH];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push_s, do_pop_s;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    entries_d = entries_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    do_pop_s  = pop && (count_q != 2'd0);
    do_push_s = push && ((count_q < 2'd2) || do_pop_s);
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push_s) begin
        entries_d[wr_ptr_q] = push_entry;
        wr_ptr_d            = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push_s} - {1'b0, do_pop_s};
    end
  end

  // Queue state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '{default: '0};
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      entries_q <= entries_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  assign head  = entries_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, credit-based memory requests, redirect/flush, 2-entry queue to decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect halts fetch and raises misalign_err.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        valid,
  input  logic        ready,
  output logic        misalign_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         misalign_err_q, misalign_err_d;

  fetch_entry_t q_head_s, resp_entry_s, head_s;
  logic [1:0]   q_count_s;
  logic         q_push_s, q_pop_s;
  logic         valid_s, handshake_s, imem_req_s, misalign_s;
  logic [2:0]   occupancy_s;

  // Handshake, credit check and queue control; an empty queue forwards the arriving word.
  always_comb begin
    resp_entry_s = '{instr: imem_rdata, pc: inflight_pc_q};
    valid_s      = (q_count_s != 2'd0) || inflight_q;
    head_s       = (q_count_s != 2'd0) ? q_head_s : resp_entry_s;
    handshake_s  = valid_s && ready;
    occupancy_s  = {1'b0, q_count_s} + {2'b00, inflight_q} - {2'b00, handshake_s};
    q_push_s     = inflight_q && !branch_taken && !((q_count_s == 2'd0) && handshake_s);
    q_pop_s      = handshake_s && (q_count_s != 2'd0) && !branch_taken;
    imem_req_s   = (state_q == S_RUN) && !branch_taken && !rst && (occupancy_s < 3'd2);
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_s   = branch_taken && (branch_target[1:0] != 2'b00);
`else
    misalign_s   = 1'b0;
`endif
  end

  // PC, in-flight tracking, sticky error and FSM next state.
  always_comb begin
    fetch_pc_d     = fetch_pc_q;
    inflight_d     = imem_req_s;
    inflight_pc_d  = inflight_pc_q;
    misalign_err_d = misalign_err_q | misalign_s;
    state_d        = state_q;
    if (branch_taken) begin
      fetch_pc_d = word_align(branch_target);
    end else if (imem_req_s) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
    if (imem_req_s) begin
      inflight_pc_d = fetch_pc_q;
    end else begin
      inflight_pc_d = inflight_pc_q;
    end
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   state_d = misalign_s ? S_HALT : S_RUN;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_BOOT;
      fetch_pc_q     <= RESET_PC;
      inflight_q     <= 1'b0;
      inflight_pc_q  <= 32'h0000_0000;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      inflight_q     <= inflight_d;
      inflight_pc_q  <= inflight_pc_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (branch_taken),
    .push       (q_push_s),
    .push_entry (resp_entry_s),
    .pop        (q_pop_s),
    .head       (q_head_s),
    .count      (q_count_s)
  );

  assign imem_req     = imem_req_s;
  assign imem_addr    = fetch_pc_q;
  assign valid        = valid_s;
  assign instruction  = valid_s ? head_s.instr : NOP_INSTR;
  assign pc_out       = valid_s ? head_s.pc : 32'h0000_0000;
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, back-pressure, redirect, wrap, misalign, mid-run reset.
module tb_instr_fetch;

  localparam logic [31:0] TAG = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        valid;
  logic        ready = 1'b1;
  logic        misalign_err;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instruction   (instruction),
    .pc_out        (pc_out),
    .valid         (valid),
    .ready         (ready),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  // Synchronous memory returning address-tagged words one cycle after a request.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr ^ TAG) : 32'hDEAD_BEEF;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic rdy, input logic br, input logic [31:0] tgt);
    @(negedge clk);
    rst           = r;
    ready         = rdy;
    branch_taken  = br;
    branch_target = tgt;
    #1;
  endtask

  task automatic exp_req(input string tag, input logic req, input logic [31:0] addr);
    check_eq({tag, ".req"}, {31'b0, imem_req}, {31'b0, req});
    if (req) check_eq({tag, ".addr"}, imem_addr, addr);
  endtask

  task automatic exp_out(input string tag, input logic v, input logic [31:0] pc);
    check_eq({tag, ".valid"}, {31'b0, valid}, {31'b0, v});
    check_eq({tag, ".pc"}, pc_out, v ? pc : 32'h0);
    check_eq({tag, ".instr"}, instruction, v ? (pc ^ TAG) : 32'h0);
  endtask

  initial begin
    // Reset values and streaming with ready high
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    exp_req("rst", 1'b0, 32'h0);
    check_eq("rst.addr", imem_addr, 32'h0000_0100);
    exp_out("rst", 1'b0, 32'h0);
    check_eq("rst.misalign", {31'b0, misalign_err}, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_req("boot", 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_req("s1", 1'b1, 32'h100); exp_out("s1", 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_req("s2", 1'b1, 32'h104); exp_out("s2", 1'b1, 32'h100);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_req("s3", 1'b1, 32'h108); exp_out("s3", 1'b1, 32'h104);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_req("s4", 1'b1, 32'h10C); exp_out("s4", 1'b1, 32'h108);

    // Back-pressure: queue saturates, then drains in order
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0); exp_req("bp1", 1'b1, 32'h100);
    cyc(1'b0, 1'b0, 1'b0, 32'h0); exp_req("bp2", 1'b1, 32'h104); exp_out("bp2", 1'b1, 32'h100);
    cyc(1'b0, 1'b0, 1'b0, 32'h0); exp_req("bp3", 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0); exp_req("bp4", 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0); exp_req("bp5", 1'b0, 32'h0); exp_out("bp5", 1'b1, 32'h100);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_req("dr1", 1'b1, 32'h108); exp_out("dr1", 1'b1, 32'h100);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_req("dr2", 1'b1, 32'h10C); exp_out("dr2", 1'b1, 32'h104);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_req("dr3", 1'b1, 32'h110); exp_out("dr3", 1'b1, 32'h108);

    // Redirect with a queued word and an in-flight word
    cyc(1'b0, 1'b0, 1'b1, 32'h200); exp_req("br0", 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_req("br1", 1'b1, 32'h200); exp_out("br1", 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_req("br2", 1'b1, 32'h204); exp_out("br2", 1'b1, 32'h200);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_out("br3", 1'b1, 32'h204);

    // Redirect near the top of the address space; fetch wraps to zero
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC); exp_req("wr0", 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_req("wr1", 1'b1, 32'hFFFF_FFFC); exp_out("wr1", 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_req("wr2", 1'b1, 32'h0000_0000); exp_out("wr2", 1'b1, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_req("wr3", 1'b1, 32'h0000_0004); exp_out("wr3", 1'b1, 32'h0);

    // Misaligned redirect
    cyc(1'b0, 1'b1, 1'b1, 32'h203);
`ifdef FETCH_MISALIGN_TRAP_EN
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_req("ma1", 1'b0, 32'h0); exp_out("ma1", 1'b0, 32'h0);
    check_eq("ma1.misalign", {31'b0, misalign_err}, 32'h1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_req("ma2", 1'b0, 32'h0); exp_out("ma2", 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_req("ma3", 1'b0, 32'h0); exp_out("ma3", 1'b0, 32'h0);
    check_eq("ma3.misalign", {31'b0, misalign_err}, 32'h1);
`else
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_req("ma1", 1'b1, 32'h200); exp_out("ma1", 1'b0, 32'h0);
    check_eq("ma1.misalign", {31'b0, misalign_err}, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0); exp_req("ma2", 1'b1, 32'h204); exp_out("ma2", 1'b1, 32'h200);
`endif

    // Reset mid-operation while a word is queued and another is in flight
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0); exp_req("mr1", 1'b1, 32'h100);
    cyc(1'b0, 1'b0, 1'b0, 32'h0); exp_req("mr2", 1'b1, 32'h104); exp_out("mr2", 1'b1, 32'h100);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0); exp_req("mr4", 1'b0, 32'h0); exp_out("mr4", 1'b0, 32'h0);
    check_eq("mr4.addr", imem_addr, 32'h0000_0100);
    check_eq("mr4.misalign", {31'b0, misalign_err}, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0); exp_req("mr5", 1'b1, 32'h100); exp_out("mr5", 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0); exp_req("mr6", 1'b1, 32'h104); exp_out("mr6", 1'b1, 32'h100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
